// File: rtl/period_capture_pkg.sv
// period_capture_pkg: shared widths and state encoding for the period capture block.
//   PC_WIDTH   - width of the period counter and of the captured result
//   PC_MAX     - saturation value of the counter (2^PC_WIDTH-1)
//   pc_state_e - measurement state machine encoding
package period_capture_pkg;

  localparam int unsigned PC_WIDTH = 9;
  localparam int unsigned PC_MAX   = (1 << PC_WIDTH) - 1;

  typedef enum logic {
    PC_IDLE    = 1'b0,
    PC_MEASURE = 1'b1
  } pc_state_e;

endpackage

// File: rtl/period_capture_if.sv
// period_capture_if: result handshake between the period capture block and its consumer.
//   periodo  - captured period in clock cycles
//   overflow - captured period exceeded PC_MAX (qualified by valid)
//   valid    - periodo/overflow hold an unconsumed result
//   ready    - consumer accepts the result when valid & ready
//   overrun  - sticky: a result was dropped while the previous one was pending
interface period_capture_if;
  import period_capture_pkg::*;

  logic [PC_WIDTH-1:0] periodo;
  logic                overflow;
  logic                valid;
  logic                ready;
  logic                overrun;

  modport master (output periodo, output overflow, output valid, output overrun, input ready);
  modport slave  (input periodo, input overflow, input valid, input overrun, output ready);

endinterface

// File: rtl/period_capture_sync_edge_detect.sv
// sync_edge_detect: samples sig_i and flags its rising edges.
//   clk    - system clock
//   reset  - synchronous, active-high
//   sig_i  - signal to watch
//   rise_o - one-cycle pulse after a 0->1 transition has been sampled
// Build option PERIOD_CAPTURE_SYNC_EN adds a two-flop synchronizer ahead of the
// sampling registers so sig_i may be asynchronous (edge latency 3 instead of 1).
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic samp;
  logic s_q;       // current registered sample
  logic s_prev_q;  // previous registered sample

`ifdef PERIOD_CAPTURE_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer for an asynchronous input
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], sig_i};
  end

  assign samp = sync_q[1];
`else
  assign samp = sig_i;
`endif

  // Current and previous sample for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      s_q      <= 1'b0;
      s_prev_q <= 1'b0;
    end else begin
      s_q      <= samp;
      s_prev_q <= s_q;
    end
  end

  assign rise_o = s_q & ~s_prev_q;

endmodule

// File: rtl/period_capture.sv
// period_capture: measures the clk-cycle interval between rising edges of sig_in
// and offers each result over a valid/ready handshake.
//   clk    - system clock
//   reset  - synchronous, active-high; clears all state
//   enable - measurement enable; low returns to IDLE, pending result is kept
//   sig_in - signal to be measured
//   bus    - result handshake (periodo, overflow, valid, ready, overrun)
// Build option PERIOD_CAPTURE_SYNC_EN enables the input synchronizer in
// sync_edge_detect; measured periods are identical in both builds.
module period_capture
  import period_capture_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  period_capture_if.master bus
);

  pc_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0] cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [PC_WIDTH-1:0] periodo_q, periodo_d;
  logic                overflow_q, overflow_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;
  logic                rise;
  logic                capture;
  logic                accept;

  sync_edge_detect u_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (sig_in),
    .rise_o (rise)
  );

  assign accept = valid_q & bus.ready;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= PC_IDLE;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      periodo_q  <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      periodo_q  <= periodo_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  // Next-state: measurement FSM, saturating counter and result handshake
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    periodo_d  = periodo_q;
    overflow_d = overflow_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    capture    = 1'b0;

    if (!enable) begin
      state_d = PC_IDLE;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        PC_IDLE: begin
          // First edge only arms the measurement
          if (rise) begin
            cnt_d   = PC_WIDTH'(1);
            state_d = PC_MEASURE;
          end
        end
        PC_MEASURE: begin
          if (rise) begin
            capture = 1'b1;
            cnt_d   = PC_WIDTH'(1);
            ovf_d   = 1'b0;
          end else if (cnt_q == PC_WIDTH'(PC_MAX)) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + PC_WIDTH'(1);
          end
        end
        default: state_d = PC_IDLE;
      endcase
    end

    // A capture wins over a simultaneous accept; otherwise it is dropped if blocked
    if (capture) begin
      if (!valid_q || bus.ready) begin
        periodo_d  = cnt_q;
        overflow_d = ovf_q;
        valid_d    = 1'b1;
        if (accept) overrun_d = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  assign bus.periodo  = periodo_q;
  assign bus.overflow = overflow_q;
  assign bus.valid    = valid_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_period_capture.sv
// tb_period_capture: directed stimulus for period_capture with an edge-timestamp
// reference model compared every cycle, plus literal expectations per scenario.
module tb_period_capture;
  import period_capture_pkg::*;

`ifdef PERIOD_CAPTURE_SYNC_EN
  localparam int D = 3;
`else
  localparam int D = 1;
`endif
  localparam int unsigned MAXV = 511;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic enable = 1'b0;
  logic sig_in = 1'b0;

  period_capture_if bus ();

  period_capture dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .sig_in (sig_in),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state: timestamps of detected rising edges
  logic [D:0]  pipe = '0;
  int unsigned edge_n = 0;
  int unsigned last_rise = 0;
  bit          armed = 1'b0;
  logic [8:0]  e_per = '0;
  logic        e_ovf = 1'b0;
  logic        e_val = 1'b0;
  logic        e_ovr = 1'b0;

  logic [9:0] acc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    sig_in = 1'b1;
    cycles(hi);
    sig_in = 1'b0;
    cycles(lo);
  endtask

  task automatic square(input int p, input int n);
    repeat (n) pulse(p / 2, p - p / 2);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    sig_in = 1'b0;
    cycles(3);
    reset = 1'b0;
    acc_q.delete();
    cycles(2);
  endtask

  task automatic check_acc(input string name, input int n, input logic ovf, input int per);
    check({name, "_count"}, acc_q.size(), n);
    for (int i = 0; i < acc_q.size(); i++) begin
      check({name, "_ovf"}, acc_q[i][9], ovf);
      check({name, "_per"}, acc_q[i][8:0], per);
    end
  endtask

  // Period = distance between edge timestamps; saturates with overflow above MAXV
  task automatic model_step();
    logic        rise;
    logic        cap;
    int unsigned per;
    edge_n++;
    cap = 1'b0;
    per = 0;
    if (reset) begin
      pipe  = '0;
      armed = 1'b0;
      e_per = '0;
      e_ovf = 1'b0;
      e_val = 1'b0;
      e_ovr = 1'b0;
    end else begin
      rise = pipe[D-1] & ~pipe[D];
      if (!enable) begin
        armed = 1'b0;
      end else if (rise) begin
        if (armed) begin
          cap = 1'b1;
          per = edge_n - last_rise;
        end
        armed     = 1'b1;
        last_rise = edge_n;
      end
      if (cap) begin
        if (!e_val || bus.ready) begin
          if (e_val) e_ovr = 1'b0;
          e_per = (per > MAXV) ? 9'(MAXV) : 9'(per);
          e_ovf = (per > MAXV);
          e_val = 1'b1;
        end else begin
          e_ovr = 1'b1;
        end
      end else if (e_val && bus.ready) begin
        e_val = 1'b0;
        e_ovr = 1'b0;
      end
      pipe = {pipe[D-1:0], sig_in};
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Records every transfer the DUT hands off (values before the edge updates them)
  initial forever begin
    @(posedge clk);
    if (!reset && bus.valid === 1'b1 && bus.ready === 1'b1)
      acc_q.push_back({bus.overflow, bus.periodo});
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", bus.valid, e_val);
      check("overrun", bus.overrun, e_ovr);
      check("periodo", bus.periodo, e_per);
      check("overflow", bus.overflow, e_ovf);
    end
  end

  initial begin
    bus.ready = 1'b0;
    cycles(2);
    chk_en = 1'b1;
    check("rst_valid", bus.valid, 0);
    check("rst_periodo", bus.periodo, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_overrun", bus.overrun, 0);
    reset = 1'b0;
    cycles(2);

    // Square wave, period 10, consumer always ready
    enable    = 1'b1;
    bus.ready = 1'b1;
    acc_q.delete();
    square(10, 5);
    cycles(8);
    check_acc("p10", 4, 1'b0, 10);

    // Saturation boundaries and minimum period
    do_reset();
    square(600, 3);
    cycles(8);
    check_acc("p600", 2, 1'b1, 511);
    do_reset();
    square(511, 3);
    cycles(8);
    check_acc("p511", 2, 1'b0, 511);
    do_reset();
    square(512, 2);
    cycles(8);
    check_acc("p512", 1, 1'b1, 511);
    do_reset();
    square(2, 6);
    cycles(8);
    check_acc("p2", 5, 1'b0, 2);

    // Consumer stalled across two captures
    do_reset();
    bus.ready = 1'b0;
    square(20, 3);
    cycles(5);
    check("stall_valid", bus.valid, 1);
    check("stall_periodo", bus.periodo, 20);
    check("stall_overrun", bus.overrun, 1);
    check("stall_count", acc_q.size(), 0);
    bus.ready = 1'b1;
    cycles(3);
    check("drain_overrun", bus.overrun, 0);
    check("drain_valid", bus.valid, 0);
    check_acc("drain", 1, 1'b0, 20);

    // Capture in the same cycle as an accept
    do_reset();
    bus.ready = 1'b0;
    pulse(10, 10);
    pulse(10, 15);
    sig_in = 1'b1;
    cycles(D);
    bus.ready = 1'b1;
    cycles(1);
    bus.ready = 1'b0;
    check("coin_valid", bus.valid, 1);
    check("coin_periodo", bus.periodo, 25);
    check("coin_overrun", bus.overrun, 0);
    check_acc("coin_acc", 1, 1'b0, 20);
    sig_in    = 1'b0;
    bus.ready = 1'b1;
    cycles(5);

    // Reset in the middle of a measurement with a result pending
    do_reset();
    bus.ready = 1'b0;
    pulse(7, 8);
    sig_in = 1'b1;
    cycles(D + 6);
    reset  = 1'b1;
    sig_in = 1'b0;
    cycles(1);
    reset = 1'b0;
    check("mid_rst_valid", bus.valid, 0);
    check("mid_rst_periodo", bus.periodo, 0);
    check("mid_rst_overflow", bus.overflow, 0);
    check("mid_rst_overrun", bus.overrun, 0);
    acc_q.delete();
    bus.ready = 1'b1;
    cycles(4);
    pulse(6, 6);
    pulse(6, 6);
    cycles(6);
    check_acc("after_rst", 1, 1'b0, 12);

    // Enable dropped for 50 cycles with a result pending
    do_reset();
    bus.ready = 1'b0;
    pulse(8, 8);
    pulse(8, 8);
    cycles(4);
    enable = 1'b0;
    cycles(10);
    pulse(5, 5);
    bus.ready = 1'b1;
    cycles(2);
    bus.ready = 1'b0;
    cycles(28);
    check_acc("dis_hand", 1, 1'b0, 16);
    check("dis_valid", bus.valid, 0);
    enable = 1'b1;
    cycles(3);
    pulse(7, 7);
    pulse(7, 7);
    bus.ready = 1'b1;
    cycles(6);
    check("reen_count", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      check("reen_first", acc_q[0][8:0], 16);
      check("reen_second", acc_q[1][8:0], 14);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
